// File: rtl/enc_out_buf_ctrl.sv
// rtl/enc_out_buf_ctrl.sv - two-slot encoder output buffer sequencer (fill slot 1, slot 2, read pair)
// Optional stall watchdog enabled by defining ENC_BUF_TIMEOUT_EN.
module enc_out_buf_ctrl #(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] num_pairs_i,
  input  logic             enc_valid_i,
  input  logic             rd_ready_i,
  output logic             buf_write_en_1_o,
  output logic             buf_write_en_2_o,
  output logic             buf_read_en_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] pair_cnt_o,
  output logic             timeout_o
);

  typedef enum logic [2:0] {IDLE, WAIT_1, WAIT_2, FULL, XFER} state_t;

  state_t           state_q, nxt, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q, busy_q, zero_done_q;
  logic             we1, we2, re, drop;
  logic             timeout_c, kill, last_pair, start_ok;

  if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  assign last_pair = (cnt_q == CNT_W'(1));
  assign start_ok  = (state_q == IDLE) && start_i && !abort_i;

  // Unkilled next state and enables; abort/timeout are applied afterwards.
  always_comb begin
    nxt  = state_q;
    we1  = 1'b0;
    we2  = 1'b0;
    re   = 1'b0;
    drop = 1'b0;
    case (state_q)
      IDLE: begin
        drop = enc_valid_i;
        if (start_i && num_pairs_i != '0) nxt = WAIT_1;
      end
      WAIT_1: if (enc_valid_i) begin
        we1 = 1'b1;
        nxt = WAIT_2;
      end
      WAIT_2: if (enc_valid_i) begin
        we2 = 1'b1;
        nxt = FULL;
      end
      FULL: begin
        drop = enc_valid_i;
        if (rd_ready_i) begin
          re  = 1'b1;
          nxt = XFER;
        end
      end
      XFER: begin
        if (last_pair) begin
          drop = enc_valid_i;
          nxt  = IDLE;
        end else if (enc_valid_i) begin
          // slot 1 contents were captured by the read, so it may be refilled now
          we1 = 1'b1;
          nxt = WAIT_2;
        end else begin
          nxt = WAIT_1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

`ifdef ENC_BUF_TIMEOUT_EN
  localparam int StallW = $clog2(TIMEOUT_CYCLES + 1);

  logic [StallW-1:0] stall_q;
  logic              stall_state;

  assign stall_state = (state_q == WAIT_1) || (state_q == WAIT_2) || (state_q == FULL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                  stall_q <= '0;
    else if (state_d != state_q || !stall_state)  stall_q <= '0;
    else                                          stall_q <= stall_q + 1'b1;
  end

  always_comb begin
    timeout_c = 1'b0;
    if (!abort_i && stall_state && nxt == state_q &&
        stall_q == StallW'(TIMEOUT_CYCLES - 1))
      timeout_c = 1'b1;
  end
`else
  always_comb begin
    timeout_c = 1'b0;
  end
`endif

  assign kill    = abort_i || timeout_c;
  assign state_d = kill ? IDLE : nxt;

  assign buf_write_en_1_o = we1 && !kill;
  assign buf_write_en_2_o = we2 && !kill;
  assign buf_read_en_o    = re && !kill;
  assign out_valid_o      = (state_q == XFER);
  assign busy_o           = busy_q;
  assign done_o           = zero_done_q || ((state_q == XFER) && last_pair && !abort_i);
  assign overflow_o       = ovf_q;
  assign pair_cnt_o       = cnt_q;
  assign timeout_o        = timeout_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != IDLE);
      zero_done_q <= start_ok && (num_pairs_i == '0);
      if (kill)                   cnt_q <= '0;
      else if (start_ok)          cnt_q <= num_pairs_i;
      else if (state_q == XFER)   cnt_q <= cnt_q - 1'b1;
      if (start_ok)               ovf_q <= 1'b0;
      else if (drop && !abort_i)  ovf_q <= 1'b1;
    end
  end

endmodule
